// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
package dmem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Width of the wait-state counter (wait counts 0..7).
    localparam int unsigned CntW = 3;

    // Default byte address of word 0.
    localparam logic [31:0] DefAddrBase = 32'h0001_0000;

endpackage

// File: rtl/dmem_resp_if.sv
// Data port between the core's memory unit (master) and the responder (slave).
interface dmem_resp_if;

    logic        dmem_i_valid;
    logic [31:0] dmem_i_addr;
    logic [3:0]  dmem_i_wmask;
    logic [31:0] dmem_i_wdata;
    logic        dmem_o_ready;
    logic        dmem_o_rvalid;
    logic [31:0] dmem_o_rdata;
    logic        dmem_o_err;

    modport master (
        output dmem_i_valid, dmem_i_addr, dmem_i_wmask, dmem_i_wdata,
        input  dmem_o_ready, dmem_o_rvalid, dmem_o_rdata, dmem_o_err
    );

    modport slave (
        input  dmem_i_valid, dmem_i_addr, dmem_i_wmask, dmem_i_wdata,
        output dmem_o_ready, dmem_o_rvalid, dmem_o_rdata, dmem_o_err
    );

endinterface

// File: rtl/dmem_bank.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
// Kept separate so it can be replaced by a vendor macro.
module dmem_bank #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic [IdxW-1:0] idx_i,
    input  logic [3:0]      we_i,
    input  logic            re_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane writes and registered read; contents are never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one word request at a time, performs it on
// the bank and returns a single response pulse after programmable wait states.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DefAddrBase,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_WAIT     = 1,
    parameter int unsigned WR_WAIT     = 0
) (
    input  logic      clk,
    input  logic      rst,
    dmem_resp_if.slave dmem
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q;
    logic [3:0]      wmask_q;
    logic [31:0]     wdata_q;
    logic            in_range_q;

    logic [31:0]     word_in;
    logic            in_range_in;
    logic [CntW-1:0] wait_in;
    logic            load;
    logic            bank_go;
    logic [IdxW-1:0] src_idx;
    logic [3:0]      src_wmask;
    logic [31:0]     src_wdata;
    logic            src_in_range;
    logic [3:0]      bank_we;
    logic            bank_re;
    logic [31:0]     bank_rdata;

    // Decode the incoming request: word index, range flag and wait count.
    always_comb begin
        word_in     = (dmem.dmem_i_addr - ADDR_BASE) >> 2;
        in_range_in = (dmem.dmem_i_addr >= ADDR_BASE) && (word_in < DEPTH_WORDS);
        wait_in     = (dmem.dmem_i_wmask == 4'b0000) ? CntW'(RD_WAIT) : CntW'(WR_WAIT);
    end

    // Next state, handshake outputs and the bank-access strobe.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        load               = 1'b0;
        bank_go            = 1'b0;
        dmem.dmem_o_ready  = 1'b0;
        dmem.dmem_o_rvalid = 1'b0;
        case (state_q)
            StIdle: begin
                dmem.dmem_o_ready = 1'b1;
                if (dmem.dmem_i_valid) begin
                    load = 1'b1;
                    if (wait_in == '0) begin
                        state_d = StResp;
                        bank_go = 1'b1;
                    end else begin
                        cnt_d   = wait_in;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                    bank_go = 1'b1;
                end
            end
            StResp: begin
                dmem.dmem_o_rvalid = 1'b1;
                state_d            = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // The bank is driven straight from the bus on a zero-wait accept,
    // otherwise from the captured request as the FSM leaves WAIT.
    always_comb begin
        src_idx      = (state_q == StIdle) ? word_in[IdxW-1:0] : idx_q;
        src_wmask    = (state_q == StIdle) ? dmem.dmem_i_wmask : wmask_q;
        src_wdata    = (state_q == StIdle) ? dmem.dmem_i_wdata : wdata_q;
        src_in_range = (state_q == StIdle) ? in_range_in : in_range_q;
        bank_we      = (bank_go && src_in_range) ? src_wmask : 4'b0000;
        bank_re      = bank_go && src_in_range && (src_wmask == 4'b0000);
    end

    // Response data and error are only meaningful during the response pulse.
    always_comb begin
        dmem.dmem_o_err   = dmem.dmem_o_rvalid && !in_range_q;
        dmem.dmem_o_rdata = (dmem.dmem_o_rvalid && in_range_q && (wmask_q == 4'b0000)) ?
                            bank_rdata : 32'h0;
    end

    // FSM state, wait counter and captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            wmask_q    <= '0;
            wdata_q    <= '0;
            in_range_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                idx_q      <= word_in[IdxW-1:0];
                wmask_q    <= dmem.dmem_i_wmask;
                wdata_q    <= dmem.dmem_i_wdata;
                in_range_q <= in_range_in;
            end
        end
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk     (clk),
        .idx_i   (src_idx),
        .we_i    (bank_we),
        .re_i    (bank_re),
        .wdata_i (src_wdata),
        .rdata_o (bank_rdata)
    );

endmodule
